// File: rtl/pipe_skid_stage.sv
// Stallable valid/ready pipeline stage with a two-entry skid buffer.
// in_ready depends only on state and rst, so it has no path from out_ready.
module pipe_skid_stage #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             consume;

  // Outputs decode straight off the state register.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != TWO) && !rst;
  assign occupancy = state;
  assign out_data  = main_q;

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          case ({accept, consume})
            2'b11: main_q <= in_data;
            2'b10: begin
              skid_q <= in_data;
              state  <= TWO;
            end
            2'b01: state <= EMPTY;
            default: ;
          endcase
        end
        TWO: begin
          // Skid word moves forward; no accept is possible here.
          if (consume) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed checks plus a scoreboard-driven random stress run for pipe_skid_stage.
module tb_pipe_skid_stage;
  localparam int W = 128;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [1:0]   occupancy;

  int checks;
  int failures;

  pipe_skid_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic v, input logic [W-1:0] d,
                           input logic [1:0] occ, input logic rdy);
    chk({tag, ".vld"}, W'(out_valid), W'(v));
    if (v) chk({tag, ".dat"}, out_data, d);
    chk({tag, ".occ"}, W'(occupancy), W'(occ));
    chk({tag, ".rdy"}, W'(in_ready), W'(rdy));
  endtask

  logic [W-1:0] q[$];
  logic         m_acc;
  logic         m_con;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Power-on reset
    step(); step();
    chk("por.vld", W'(out_valid), '0);
    chk("por.dat", out_data, '0);
    chk("por.occ", W'(occupancy), '0);
    chk("por.rdy", W'(in_ready), '0);
    rst = 1'b0;
    #1 chk("por.rdy_rel", W'(in_ready), W'(1));

    // Pass-through
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 678; step(); chk_state("pt0", 1, 678, 1, 1);
    in_data = 123; step(); chk_state("pt1", 1, 123, 1, 1);
    in_data = 25;  step(); chk_state("pt2", 1, 25, 1, 1);
    in_valid = 1'b0; step(); chk_state("pt3", 0, 0, 0, 1);

    // Stall and skid
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 678; step(); chk_state("sk0", 1, 678, 1, 1);
    in_data = 123; step(); chk_state("sk1", 1, 678, 2, 0);
    in_data = 25;  step(); chk_state("sk2", 1, 678, 2, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    step(); chk_state("sk3", 1, 123, 1, 1);
    in_valid = 1'b1; in_data = 25;
    step(); chk_state("sk4", 1, 25, 1, 1);
    in_valid = 1'b0;
    step(); chk_state("sk5", 0, 0, 0, 1);

    // Simultaneous accept and consume in ONE
    out_ready = 1'b0; in_valid = 1'b1; in_data = 678;
    step(); chk_state("ac0", 1, 678, 1, 1);
    in_data = 123; out_ready = 1'b1;
    step(); chk_state("ac1", 1, 123, 1, 1);
    in_valid = 1'b0;
    step(); chk_state("ac2", 0, 0, 0, 1);

    // Flush from TWO with a concurrent consume
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 678; step();
    in_data = 123; step(); chk_state("fl0", 1, 678, 2, 0);
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    step();
    chk_state("fl1", 0, 0, 0, 1);
    chk("fl1.dat0", out_data, '0);
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk("fl.none", W'(out_valid), '0);
    end

    // Asynchronous reset mid-stream in TWO
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 678; step();
    in_data = 123; step(); chk_state("rs0", 1, 678, 2, 0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rs.vld", W'(out_valid), '0);
    chk("rs.dat", out_data, '0);
    chk("rs.occ", W'(occupancy), '0);
    chk("rs.rdy", W'(in_ready), '0);
    in_valid = 1'b1; in_data = 99; out_ready = 1'b1;
    step();
    chk("rs.edge_occ", W'(occupancy), '0);
    chk("rs.edge_rdy", W'(in_ready), '0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1 chk("rs.rdy_rel", W'(in_ready), W'(1));
    step(); chk_state("rs1", 0, 0, 0, 1);

    // Random stress against a reference queue
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      chk("st.vld", W'(out_valid), W'(q.size() > 0));
      chk("st.occ", W'(occupancy), W'(q.size()));
      chk("st.rdy", W'(in_ready), W'(q.size() < 2));
      if (q.size() > 0) chk("st.dat", out_data, q[0]);
      in_valid  = ($urandom_range(9) < 6);
      out_ready = ($urandom_range(9) < 6);
      flush     = ($urandom_range(99) < 3);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      m_acc = in_valid && (q.size() < 2);
      m_con = out_ready && (q.size() > 0);
      if (flush) q.delete();
      else begin
        if (m_con) void'(q.pop_front());
        if (m_acc) q.push_back(in_data);
      end
      step();
    end
    flush = 1'b0; in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
